// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath with operand forwarding,
// a valid/ready instruction port and a back-pressured output register.
module datapath_pipe #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int ZERO_REG = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [2:0]                  op,
   input  logic [$clog2(NUM_REGS)-1:0] wa,
   input  logic [$clog2(NUM_REGS)-1:0] raa,
   input  logic [$clog2(NUM_REGS)-1:0] rab,
   input  logic [DATA_W-1:0]           in_data,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        flag
);

   localparam int AW = $clog2(NUM_REGS);
   localparam bit ZR = (ZERO_REG != 0);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_EQ   = 3'b010,
      OP_AND  = 3'b011,
      OP_MOV  = 3'b100,
      OP_LOAD = 3'b101,
      OP_OUT  = 3'b110,
      OP_NOP  = 3'b111
   } op_t;

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic              e_valid;
   op_t               e_op;
   logic [AW-1:0]     e_wa;
   logic [DATA_W-1:0] e_a;
   logic [DATA_W-1:0] e_b;
   logic [DATA_W-1:0] e_imm;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] e_res;
   logic              e_wr;
   logic              e_commit;
   logic              accept;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   // Execute-stage result and whether the op writes the register file
   always_comb begin
      sum   = {1'b0, e_a} + {1'b0, e_b};
      diff  = {1'b0, e_a} - {1'b0, e_b};
      e_res = '0;
      e_wr  = 1'b0;
      case (e_op)
         OP_ADD:  begin e_res = sum[DATA_W-1:0];  e_wr = 1'b1; end
         OP_SUB:  begin e_res = diff[DATA_W-1:0]; e_wr = 1'b1; end
         OP_AND:  begin e_res = e_a & e_b;        e_wr = 1'b1; end
         OP_MOV:  begin e_res = e_a;              e_wr = 1'b1; end
         OP_LOAD: begin e_res = e_imm;            e_wr = 1'b1; end
         default: begin e_res = '0;               e_wr = 1'b0; end
      endcase
   end

   // A write to the hardwired zero register is dropped, so it must not forward either
   assign e_commit = e_valid && e_wr && !(ZR && (e_wa == '0));

   // Decode-stage operand read with forwarding from the committing E op
   always_comb begin
      if (e_commit && (e_wa == raa))   opnd_a = e_res;
      else if (ZR && (raa == '0))      opnd_a = '0;
      else                             opnd_a = regs[raa];
      if (e_commit && (e_wa == rab))   opnd_b = e_res;
      else if (ZR && (rab == '0))      opnd_b = '0;
      else                             opnd_b = regs[rab];
   end

   // OUT in E holds issue for one cycle so the output register is free when it lands
   assign op_ready = !(out_valid && !out_ready) && !(e_valid && (e_op == OP_OUT));
   assign accept   = op_valid && op_ready;

   // Execute-stage pipeline register; a cycle without accept inserts a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid <= 1'b0;
         e_op    <= OP_NOP;
         e_wa    <= '0;
         e_a     <= '0;
         e_b     <= '0;
         e_imm   <= '0;
      end else begin
         e_valid <= accept;
         if (accept) begin
            e_op  <= op_t'(op);
            e_wa  <= wa;
            e_a   <= opnd_a;
            e_b   <= opnd_b;
            e_imm <= in_data;
         end
      end
   end

   // Register-file write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (e_commit) begin
         regs[e_wa] <= e_res;
      end
   end

   // Status flag; AND, LOAD, OUT and NOP leave it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag <= 1'b0;
      end else if (e_valid) begin
         case (e_op)
            OP_ADD:  flag <= sum[DATA_W];
            OP_SUB:  flag <= diff[DATA_W];
            OP_EQ:   flag <= (e_a == e_b);
            OP_MOV:  flag <= 1'b0;
            default: flag <= flag;
         endcase
      end
   end

   // Output register: an OUT commit loads it, a sink handshake empties it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (e_valid && (e_op == OP_OUT)) begin
         out_valid <= 1'b1;
         out_data  <= e_a;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: two 8-bit/16-register instances that
// differ only in ZERO_REG share one stimulus; a 16-bit/32-register instance
// has its own. Register contents are observed through OUT and a scoreboard.
module tb_datapath_pipe;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, EQ = 3'd2, AND_ = 3'd3;
   localparam logic [2:0] MOV = 3'd4, LOAD = 3'd5, OUT = 3'd6, NOP = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, op_valid, out_ready;
   logic [2:0] op;
   logic [3:0] wa, raa, rab;
   logic [7:0] in_data;
   logic       op_ready0, out_valid0, flag0;
   logic [7:0] out_data0;
   logic       op_ready1, out_valid1, flag1;
   logic [7:0] out_data1;

   logic        rst_n2, op_valid2, out_ready2;
   logic [2:0]  op2;
   logic [4:0]  wa2, raa2, rab2;
   logic [15:0] in_data2;
   logic        op_ready2, out_valid2, flag2;
   logic [15:0] out_data2;

   datapath_pipe #(.DATA_W(8), .NUM_REGS(16), .ZERO_REG(0)) u0 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready0), .op(op),
      .wa(wa), .raa(raa), .rab(rab), .in_data(in_data), .out_data(out_data0),
      .out_valid(out_valid0), .out_ready(out_ready), .flag(flag0));

   datapath_pipe #(.DATA_W(8), .NUM_REGS(16), .ZERO_REG(1)) u1 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready1), .op(op),
      .wa(wa), .raa(raa), .rab(rab), .in_data(in_data), .out_data(out_data1),
      .out_valid(out_valid1), .out_ready(out_ready), .flag(flag1));

   datapath_pipe #(.DATA_W(16), .NUM_REGS(32), .ZERO_REG(0)) u2 (
      .clk(clk), .rst_n(rst_n2), .op_valid(op_valid2), .op_ready(op_ready2), .op(op2),
      .wa(wa2), .raa(raa2), .rab(rab2), .in_data(in_data2), .out_data(out_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .flag(flag2));

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] q0[$], q1[$], q2[$];
   logic [15:0] exp0, exp1, exp2;
   int s;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboards: each sink handshake pops the oldest expected OUT value
   always @(negedge clk) begin
      if (out_valid0 && out_ready) begin
         exp0 = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
         check("out_u0", {8'h00, out_data0}, exp0);
      end
      if (out_valid1 && out_ready) begin
         exp1 = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
         check("out_u1", {8'h00, out_data1}, exp1);
      end
      if (out_valid2 && out_ready2) begin
         exp2 = (q2.size() > 0) ? q2.pop_front() : 16'hxxxx;
         check("out_u2", out_data2, exp2);
      end
   end

   // Drive one instruction; returns #1 after the accepting edge with stall count
   task automatic issue_a(input logic [2:0] o, input logic [3:0] w, a, b,
                          input logic [7:0] imm, output int stalls);
      op_valid = 1'b1; op = o; wa = w; raa = a; rab = b; in_data = imm;
      stalls = 0;
      @(negedge clk);
      while (!op_ready0 && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 50) check("issue_a_timeout", {15'd0, op_ready0}, 16'd1);
      @(posedge clk); #1;
      op_valid = 1'b0; op = NOP;
   endtask

   task automatic do_a(input logic [2:0] o, input logic [3:0] w, a, b, input logic [7:0] imm);
      int st;
      issue_a(o, w, a, b, imm, st);
   endtask

   task automatic out_a(input logic [3:0] r, input logic [7:0] e0, e1);
      q0.push_back({8'h00, e0});
      q1.push_back({8'h00, e1});
      do_a(OUT, 4'd0, r, 4'd0, 8'd0);
   endtask

   task automatic nop_a;
      @(posedge clk); #1;
   endtask

   task automatic do_b(input logic [2:0] o, input logic [4:0] w, a, b, input logic [15:0] imm);
      int st;
      op_valid2 = 1'b1; op2 = o; wa2 = w; raa2 = a; rab2 = b; in_data2 = imm;
      st = 0;
      @(negedge clk);
      while (!op_ready2 && st < 50) begin
         st++;
         @(negedge clk);
      end
      if (st >= 50) check("issue_b_timeout", {15'd0, op_ready2}, 16'd1);
      @(posedge clk); #1;
      op_valid2 = 1'b0; op2 = NOP;
   endtask

   task automatic out_b(input logic [4:0] r, input logic [15:0] e);
      q2.push_back(e);
      do_b(OUT, 5'd0, r, 5'd0, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst_n2 = 1'b0;
      op_valid = 1'b0; op = NOP; wa = '0; raa = '0; rab = '0; in_data = '0; out_ready = 1'b1;
      op_valid2 = 1'b0; op2 = NOP; wa2 = '0; raa2 = '0; rab2 = '0; in_data2 = '0; out_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; rst_n2 = 1'b1;

      @(negedge clk);
      check("rst_op_ready", {15'd0, op_ready0}, 16'd1);
      check("rst_out_valid", {15'd0, out_valid0}, 16'd0);
      check("rst_flag", {15'd0, flag0}, 16'd0);
      check("rst_out_data", {8'h00, out_data0}, 16'd0);
      @(posedge clk); #1;

      // ALU operations and flag behaviour
      do_a(LOAD, 4'd1, 4'd0, 4'd0, 8'd200);
      do_a(LOAD, 4'd2, 4'd0, 4'd0, 8'd100);
      do_a(ADD, 4'd3, 4'd1, 4'd2, 8'd0);
      nop_a;
      check("add_carry", {15'd0, flag0}, 16'd1);
      check("add_carry_u1", {15'd0, flag1}, 16'd1);
      do_a(ADD, 4'd4, 4'd2, 4'd2, 8'd0);
      nop_a;
      check("add_nocarry", {15'd0, flag0}, 16'd0);
      do_a(SUB, 4'd5, 4'd2, 4'd1, 8'd0);
      nop_a;
      check("sub_borrow", {15'd0, flag0}, 16'd1);
      do_a(EQ, 4'd0, 4'd1, 4'd2, 8'd0);
      nop_a;
      check("eq_false", {15'd0, flag0}, 16'd0);
      do_a(EQ, 4'd0, 4'd1, 4'd1, 8'd0);
      nop_a;
      check("eq_true", {15'd0, flag0}, 16'd1);
      do_a(AND_, 4'd7, 4'd1, 4'd2, 8'd0);
      nop_a;
      check("and_flag_hold", {15'd0, flag0}, 16'd1);
      do_a(MOV, 4'd6, 4'd1, 4'd0, 8'd0);
      nop_a;
      check("mov_flag", {15'd0, flag0}, 16'd0);
      out_a(4'd3, 8'd44, 8'd44);
      out_a(4'd4, 8'd200, 8'd200);
      out_a(4'd5, 8'd156, 8'd156);
      out_a(4'd6, 8'd200, 8'd200);
      out_a(4'd7, 8'd64, 8'd64);
      out_a(4'd1, 8'd200, 8'd200);
      out_a(4'd2, 8'd100, 8'd100);
      nop_a; nop_a;

      // Back-to-back dependent chain ending in OUT
      issue_a(LOAD, 4'd1, 4'd0, 4'd0, 8'd5, s);
      check("load_stall", s[15:0], 16'd0);
      issue_a(ADD, 4'd2, 4'd1, 4'd1, 8'd0, s);
      check("fwd_add_stall", s[15:0], 16'd0);
      q0.push_back(16'd10);
      q1.push_back(16'd10);
      issue_a(OUT, 4'd0, 4'd2, 4'd0, 8'd0, s);
      check("fwd_out_stall", s[15:0], 16'd0);
      @(negedge clk);
      check("out_bubble", {15'd0, op_ready0}, 16'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("after_bubble", {15'd0, op_ready0}, 16'd1);
      @(posedge clk); #1;
      nop_a;

      // Back-pressure: a held LOAD must not be accepted while the output is full
      out_ready = 1'b0;
      out_a(4'd3, 8'd44, 8'd44);
      op_valid = 1'b1; op = LOAD; wa = 4'd3; in_data = 8'd99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stall", {15'd0, op_ready0}, 16'd0);
         @(posedge clk); #1;
      end
      check("bp_out_valid", {15'd0, out_valid0}, 16'd1);
      check("bp_out_data", {8'h00, out_data0}, 16'd44);
      op_valid = 1'b0; op = NOP;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {15'd0, op_ready0}, 16'd1);
      @(posedge clk); #1;
      out_a(4'd3, 8'd44, 8'd44);
      nop_a; nop_a;

      // Zero register: u1 discards the write and reads 0
      do_a(LOAD, 4'd0, 4'd0, 4'd0, 8'd77);
      out_a(4'd0, 8'd77, 8'd0);
      repeat (4) nop_a;
      check("q0_drained", q0.size(), 16'd0);
      check("q1_drained", q1.size(), 16'd0);

      // Wide configuration and asynchronous reset with an ADD in E
      do_b(LOAD, 5'd30, 5'd0, 5'd0, 16'hFFFF);
      do_b(LOAD, 5'd29, 5'd0, 5'd0, 16'h0001);
      do_b(ADD, 5'd31, 5'd30, 5'd29, 16'd0);
      nop_a;
      check("wide_carry", {15'd0, flag2}, 16'd1);
      out_b(5'd31, 16'h0000);
      repeat (3) nop_a;
      do_b(ADD, 5'd1, 5'd30, 5'd30, 16'd0);
      rst_n2 = 1'b0;
      #2;
      check("rst_mid_flag", {15'd0, flag2}, 16'd0);
      #1;
      rst_n2 = 1'b1;
      nop_a;
      check("post_rst_flag", {15'd0, flag2}, 16'd0);
      check("post_rst_out_valid", {15'd0, out_valid2}, 16'd0);
      check("post_rst_out_data", out_data2, 16'd0);
      check("post_rst_ready", {15'd0, op_ready2}, 16'd1);
      out_b(5'd1, 16'h0000);
      out_b(5'd29, 16'h0000);
      out_b(5'd30, 16'h0000);
      out_b(5'd31, 16'h0000);
      repeat (4) nop_a;
      check("q2_drained", q2.size(), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
